// File: rtl/exec_mem_stage_pkg.sv
// Shared types and default widths for the NanoQuarter execute/memory stage.
package exec_mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DEF_DW      = 16;
    localparam int DEF_AW      = 6;
    localparam int DEF_PCW     = 32;
    localparam int DEF_BOFFW   = 5;
    localparam int DEF_JTW     = 8;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/exec_mem_stage_if.sv
// Pipeline handshake, result and APB bus signals of the execute/memory stage.
interface exec_mem_stage_if import exec_mem_stage_pkg::*; #(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int PCW   = DEF_PCW,
    parameter int BOFFW = DEF_BOFFW,
    parameter int JTW   = DEF_JTW
);
    logic             in_valid;
    logic             in_ready;
    logic             stall;
    logic [DW-1:0]    alu_in;
    logic [DW-1:0]    reg1_in;
    logic [DW-1:0]    reg2_in;
    logic [AW-1:0]    memaddr_in;
    logic [BOFFW-1:0] boffset_in;
    logic [JTW-1:0]   jtarget_in;
    logic             bne_in;
    logic             jmp_in;
    logic             jr_in;
    logic             memread_in;
    logic             memwrite_in;
    logic [PCW-1:0]   pc_in;
    logic             out_valid;
    logic [DW-1:0]    wb_data;
    logic [PCW-1:0]   pc_out;
    logic             mem_err;
    logic [AW-1:0]    paddr;
    logic             pwrite;
    logic             psel;
    logic             penable;
    logic [DW-1:0]    pwdata;
    logic [DW-1:0]    prdata;
    logic             pready;
    logic             pslverr;

    modport master (
        input  in_valid, alu_in, reg1_in, reg2_in, memaddr_in, boffset_in, jtarget_in,
               bne_in, jmp_in, jr_in, memread_in, memwrite_in, pc_in,
               prdata, pready, pslverr,
        output in_ready, stall, out_valid, wb_data, pc_out, mem_err,
               paddr, pwrite, psel, penable, pwdata
    );

    modport slave (
        output in_valid, alu_in, reg1_in, reg2_in, memaddr_in, boffset_in, jtarget_in,
               bne_in, jmp_in, jr_in, memread_in, memwrite_in, pc_in,
               prdata, pready, pslverr,
        input  in_ready, stall, out_valid, wb_data, pc_out, mem_err,
               paddr, pwrite, psel, penable, pwdata
    );

endinterface

// File: rtl/exec_mem_stage_apb_master_fsm.sv
// Stage sequencer: accepts instructions, runs the APB SETUP/ACCESS phases with
// a timeout down-counter, and reports completion with read data and error.
//
//   state  | meaning
//   IDLE   | ready for a new instruction
//   SETUP  | APB setup phase (psel=1, penable=0)
//   ACCESS | APB access phase, waiting for pready or timeout
//   DONE   | result strobe cycle, no accept
module apb_master_fsm import exec_mem_stage_pkg::*; #(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic          mem_i,
    input  logic          write_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [DW-1:0] prdata_i,
    input  logic          pready_i,
    input  logic          pslverr_i,
    output state_e        state_o,
    output logic          accept_o,
    output logic          done_o,
    output logic [DW-1:0] rdata_o,
    output logic          err_o,
    output logic          psel_o,
    output logic          penable_o,
    output logic          pwrite_o,
    output logic [AW-1:0] paddr_o,
    output logic [DW-1:0] pwdata_o
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;

    // APB strobes are flops on the async reset so a reset drops them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        accept_o  = 1'b0;
        done_o    = 1'b0;
        rdata_o   = '0;
        err_o     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    accept_o = 1'b1;
                    if (mem_i) begin
                        state_d  = ST_SETUP;
                        psel_d   = 1'b1;
                        paddr_d  = addr_i;
                        pwrite_d = write_i;
                        pwdata_d = wdata_i;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                cnt_d     = CW'(TIMEOUT - 1);
            end
            ST_ACCESS: begin
                // Terminal count is checked after pready, so a response in the last allowed cycle still succeeds.
                if (pready_i || (cnt_q == '0)) begin
                    state_d   = ST_DONE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_o    = 1'b1;
                    err_o     = pready_i ? pslverr_i : 1'b1;
                    rdata_o   = (pready_i && !pslverr_i && !pwrite_q) ? prdata_i : '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign state_o   = state_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = pwrite_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;

endmodule

// File: rtl/exec_mem_stage.sv
// NanoQuarter execute/memory stage: next-PC resolution, APB load/store and
// registered write-back result with a valid/ready front end.
module exec_mem_stage import exec_mem_stage_pkg::*; #(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int PCW     = DEF_PCW,
    parameter int BOFFW   = DEF_BOFFW,
    parameter int JTW     = DEF_JTW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic              clk,
    input logic              rst,
    exec_mem_stage_if.master bus
);
    state_e         state;
    logic           accept, mem_done, acc_err, is_mem;
    logic [DW-1:0]  acc_rdata;
    logic [PCW-1:0] pc_seq, pc_next;
    logic [PCW-1:0] pc_lat_q, pc_q, pc_d;
    logic [DW-1:0]  alu_lat_q, wb_q, wb_d;
    logic           load_lat_q, err_q, err_d;

    assign is_mem = bus.memread_in | bus.memwrite_in;

    always_comb begin
        pc_seq  = bus.pc_in + PCW'(1);
        pc_next = pc_seq;
        if (bus.jmp_in)
            pc_next = bus.jr_in ? PCW'(bus.reg1_in) : PCW'(bus.jtarget_in);
        else if (bus.bne_in && (bus.reg1_in != bus.reg2_in))
            pc_next = pc_seq + PCW'($signed(bus.boffset_in));
    end

    // Non-memory ops finish on the accept edge; memory ops use the latched copy.
    always_comb begin
        wb_d  = wb_q;
        pc_d  = pc_q;
        err_d = err_q;
        if (accept && !is_mem) begin
            wb_d  = bus.alu_in;
            pc_d  = pc_next;
            err_d = 1'b0;
        end else if (mem_done) begin
            wb_d  = load_lat_q ? acc_rdata : alu_lat_q;
            pc_d  = pc_lat_q;
            err_d = acc_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_lat_q   <= '0;
            alu_lat_q  <= '0;
            load_lat_q <= 1'b0;
            wb_q       <= '0;
            pc_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                pc_lat_q   <= pc_next;
                alu_lat_q  <= bus.alu_in;
                load_lat_q <= bus.memread_in;
            end
            wb_q  <= wb_d;
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    apb_master_fsm #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (bus.in_valid),
        .mem_i     (is_mem),
        .write_i   (bus.memwrite_in & ~bus.memread_in),
        .addr_i    (bus.memaddr_in),
        .wdata_i   (bus.reg2_in),
        .prdata_i  (bus.prdata),
        .pready_i  (bus.pready),
        .pslverr_i (bus.pslverr),
        .state_o   (state),
        .accept_o  (accept),
        .done_o    (mem_done),
        .rdata_o   (acc_rdata),
        .err_o     (acc_err),
        .psel_o    (bus.psel),
        .penable_o (bus.penable),
        .pwrite_o  (bus.pwrite),
        .paddr_o   (bus.paddr),
        .pwdata_o  (bus.pwdata)
    );

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.stall     = (state != ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.wb_data   = wb_q;
    assign bus.pc_out    = pc_q;
    assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_exec_mem_stage.sv
// Scoreboard bench for exec_mem_stage: driver pushes expected results, an APB
// slave model answers with scripted waits/errors, a monitor checks each strobe.
module tb_exec_mem_stage;
    localparam int DW = 16, AW = 6, PCW = 32, BOFFW = 5, JTW = 8, TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exec_mem_stage_if #(.DW(DW), .AW(AW), .PCW(PCW), .BOFFW(BOFFW), .JTW(JTW)) bus ();

    exec_mem_stage #(.DW(DW), .AW(AW), .PCW(PCW), .BOFFW(BOFFW), .JTW(JTW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0]    alu, reg1, reg2;
        logic [AW-1:0]    addr;
        logic [BOFFW-1:0] boff;
        logic [JTW-1:0]   jt;
        logic             bne, jmp, jr, mr, mw;
        logic [PCW-1:0]   pc;
        int               waits;
        logic             slverr;
        logic [DW-1:0]    rdata;
    } txn_t;

    typedef struct {
        logic [DW-1:0]  wb;
        logic [PCW-1:0] pc;
        logic           err;
        int             cyc;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        int            waits;
        logic          slverr;
        logic [DW-1:0] rdata;
    } cfg_t;

    exp_t sbq[$];
    cfg_t cfgq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: next PC from plain integer arithmetic modulo 2^PCW.
    function automatic logic [PCW-1:0] ref_pc(input txn_t t);
        longint m, seq, off;
        m   = longint'(1) <<< PCW;
        seq = (longint'(t.pc) + 1) % m;
        if (t.jmp) return t.jr ? PCW'(longint'(t.reg1)) : PCW'(longint'(t.jt));
        off = longint'(t.boff);
        if (off >= (longint'(1) <<< (BOFFW - 1))) off = off - (longint'(1) <<< BOFFW);
        if (t.bne && (t.reg1 != t.reg2)) return PCW'((seq + off + m) % m);
        return PCW'(seq);
    endfunction

    function automatic exp_t ref_exp(input txn_t t, input int a);
        exp_t e;
        e.pc = ref_pc(t);
        if (!(t.mr || t.mw)) begin
            e.wb = t.alu; e.err = 1'b0; e.cyc = a + 1;
        end else if (t.waits >= TIMEOUT) begin
            e.wb = t.mr ? '0 : t.alu; e.err = 1'b1; e.cyc = a + 2 + TIMEOUT;
        end else begin
            e.wb = t.mr ? (t.slverr ? '0 : t.rdata) : t.alu;
            e.err = t.slverr; e.cyc = a + 3 + t.waits;
        end
        return e;
    endfunction

    function automatic txn_t mk();
        txn_t t = '{default: 0};
        return t;
    endfunction

    function automatic txn_t rnd();
        txn_t t = '{default: 0};
        int   r;
        t.alu  = DW'($urandom);
        t.reg1 = DW'($urandom);
        t.reg2 = ($urandom_range(0, 2) == 0) ? t.reg1 : DW'($urandom);
        t.addr = AW'($urandom);
        t.boff = BOFFW'($urandom);
        t.jt   = JTW'($urandom);
        t.bne  = ($urandom_range(0, 2) == 0);
        t.jmp  = ($urandom_range(0, 3) == 0);
        t.jr   = $urandom_range(0, 1) == 1;
        t.mr   = ($urandom_range(0, 3) == 0);
        t.mw   = ($urandom_range(0, 3) == 0);
        t.pc   = ($urandom_range(0, 7) == 0) ? '1 : PCW'($urandom);
        r = $urandom_range(0, 9);
        t.waits  = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? TIMEOUT - 1 : (r == 8) ? TIMEOUT : 40;
        t.slverr = ($urandom_range(0, 5) == 0);
        t.rdata  = DW'($urandom);
        return t;
    endfunction

    task automatic scramble_inputs();
        bus.alu_in     = DW'($urandom);
        bus.reg1_in    = DW'($urandom);
        bus.reg2_in    = DW'($urandom);
        bus.memaddr_in = AW'($urandom);
        bus.boffset_in = BOFFW'($urandom);
        bus.jtarget_in = JTW'($urandom);
        bus.pc_in      = PCW'($urandom);
        bus.bne_in = 1'b0; bus.jmp_in = 1'b0; bus.jr_in = 1'b0;
        bus.memread_in = 1'b0; bus.memwrite_in = 1'b0;
    endtask

    task automatic issue(input txn_t t);
        int   guard = 0;
        int   a;
        exp_t e;
        cfg_t c;
        @(negedge clk);
        bus.alu_in = t.alu; bus.reg1_in = t.reg1; bus.reg2_in = t.reg2;
        bus.memaddr_in = t.addr; bus.boffset_in = t.boff; bus.jtarget_in = t.jt;
        bus.bne_in = t.bne; bus.jmp_in = t.jmp; bus.jr_in = t.jr;
        bus.memread_in = t.mr; bus.memwrite_in = t.mw; bus.pc_in = t.pc;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", bus.in_ready, 1);
            bus.in_valid = 1'b0;
            return;
        end
        a = cyc;
        e = ref_exp(t, a);
        c.addr = t.addr; c.wr = t.mw && !t.mr; c.wdata = t.reg2;
        c.waits = t.waits; c.slverr = t.slverr; c.rdata = t.rdata;
        @(posedge clk);
        sbq.push_back(e);
        if (t.mr || t.mw) cfgq.push_back(c);
        #1;
        bus.in_valid = 1'b0;
        scramble_inputs();
    endtask

    // APB slave model driven from the scripted per-transaction configuration.
    initial begin
        cfg_t cur = '{default: 0};
        int   wl = 0;
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.pready = 1'b0;
            end else if (bus.psel && !bus.penable) begin
                if (cfgq.size() == 0) begin
                    chk("spurious_psel", bus.psel, 0);
                end else begin
                    cur = cfgq.pop_front();
                    wl  = cur.waits;
                    chk("paddr", bus.paddr, cur.addr);
                    chk("pwrite", bus.pwrite, cur.wr);
                    if (cur.wr) chk("pwdata", bus.pwdata, cur.wdata);
                end
                bus.pready = 1'b0; bus.prdata = DW'($urandom);
            end else if (bus.psel && bus.penable) begin
                chk("paddr_stable", bus.paddr, cur.addr);
                if (wl == 0) begin
                    bus.pready = 1'b1; bus.pslverr = cur.slverr; bus.prdata = cur.rdata;
                end else begin
                    bus.pready = 1'b0; bus.pslverr = $urandom_range(0, 1) == 1;
                    bus.prdata = DW'($urandom);
                    wl--;
                end
            end else begin
                bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = DW'($urandom);
            end
        end
    end

    // Monitor: handshake state every cycle, result on each strobe.
    initial begin
        exp_t e;
        logic busy;
        forever begin
            @(negedge clk);
            if (rst) continue;
            busy = (sbq.size() != 0);
            chk("in_ready", bus.in_ready, !busy);
            chk("stall", bus.stall, busy);
            if (bus.out_valid) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out_valid", bus.out_valid, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("wb_data", bus.wb_data, e.wb);
                    chk("pc_out", bus.pc_out, e.pc);
                    chk("mem_err", bus.mem_err, e.err);
                    chk("latency_cycle", cyc, e.cyc);
                    chk("psel_at_done", bus.psel, 0);
                end
            end else if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
                chk("out_valid_missing", bus.out_valid, 1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int   g;
        bus.in_valid = 1'b0;
        scramble_inputs();
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_stall", bus.stall, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_pc_out", bus.pc_out, 0);
        chk("rst_mem_err", bus.mem_err, 0);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_pwrite", bus.pwrite, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        t = mk(); t.alu = 16'h1234; t.pc = 7; issue(t);
        t = mk(); t.bne = 1; t.reg1 = 3; t.reg2 = 4; t.boff = 5'b11110; t.pc = 10; issue(t);
        t = mk(); t.bne = 1; t.reg1 = 3; t.reg2 = 3; t.boff = 5'b11110; t.pc = 10; issue(t);
        t = mk(); t.pc = 32'hFFFF_FFFF; issue(t);
        t = mk(); t.bne = 1; t.reg1 = 1; t.reg2 = 2; t.boff = 5'b01111; t.pc = 32'hFFFF_FFF8; issue(t);
        t = mk(); t.jmp = 1; t.jr = 1; t.reg1 = 16'h0040; t.bne = 1; t.reg2 = 5; t.pc = 3; issue(t);
        t = mk(); t.jmp = 1; t.jr = 0; t.jt = 8'hA5; t.reg1 = 16'hFFFF; issue(t);
        t = mk(); t.mr = 1; t.addr = 5; t.waits = 2; t.rdata = 16'hBEEF; t.alu = 16'h1111; t.pc = 20; issue(t);
        t = mk(); t.mw = 1; t.addr = 6'h2A; t.reg2 = 16'hCAFE; t.alu = 16'h0777; t.waits = 100; issue(t);
        t = mk(); t.mr = 1; t.addr = 9; t.waits = 1; t.slverr = 1; t.rdata = 16'h5555; issue(t);
        t = mk(); t.mr = 1; t.addr = 1; t.waits = TIMEOUT - 1; t.rdata = 16'hA5A5; issue(t);
        t = mk(); t.mr = 1; t.mw = 1; t.addr = 3; t.waits = 0; t.rdata = 16'h0F0F; issue(t);
        t = mk(); t.mw = 1; t.addr = 4; t.reg2 = 16'h1357; t.alu = 16'h2468; t.waits = 0; t.slverr = 1; issue(t);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(rnd());
        end

        g = 0;
        while (sbq.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain_before_reset", sbq.size(), 0);

        t = mk(); t.mr = 1; t.addr = 7; t.waits = 1000; issue(t);
        @(posedge clk);
        #2;
        chk("psel_before_rst", bus.psel, 1);
        chk("penable_before_rst", bus.penable, 1);
        rst = 1'b1;
        #1;
        chk("midrst_psel", bus.psel, 0);
        chk("midrst_penable", bus.penable, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        sbq.delete();
        cfgq.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_pc_out", bus.pc_out, 0);
        chk("post_rst_wb_data", bus.wb_data, 0);

        t = mk(); t.alu = 16'h4321; t.pc = 100; issue(t);
        g = 0;
        while (sbq.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("final_drain", sbq.size(), 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
